// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state and transaction owner encodings.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam int LAT_CNT_W  = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF/LSU request-response channels and the shared memory port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic              if_rsp_ready;
  logic [DATA_W-1:0] if_rsp_rdata;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic                lsu_req_we;
  logic [ADDR_W-1:0]   lsu_req_addr;
  logic [DATA_W-1:0]   lsu_req_wdata;
  logic [DATA_W/8-1:0] lsu_req_wmask;
  logic                lsu_rsp_valid;
  logic                lsu_rsp_ready;
  logic [DATA_W-1:0]   lsu_rsp_rdata;

  logic                mem_ce;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: bit 0 = IF, bit 1 = LSU; a tie goes to the side not granted last.
module mem_arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  owner_e     i_last_grant,
  output logic [1:0] o_grant
);

  // grant selection
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == OWN_IF) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a time,
// with a fixed MEM_LAT-cycle access window driven purely from latched request state.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_arbiter_if.slave  io_bus
);

  localparam int                 MASK_W   = DATA_W / 8;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  owner_e                r_owner;
  owner_e                r_last_grant;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [MASK_W-1:0]     r_wmask;
  logic [LAT_CNT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0]     r_rdata;

  logic [1:0] w_grant;
  logic       w_if_ready;
  logic       w_lsu_ready;
  logic       w_access;
  logic       w_resp;
  logic       w_rsp_hs;

  mem_arb_rr2 u_rr (
    .i_valid      ({io_bus.lsu_req_valid, io_bus.if_req_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_access = (r_state == ST_ACCESS);
  assign w_resp   = (r_state == ST_RESP);
  assign w_rsp_hs = w_resp & ((r_owner == OWN_IF) ? io_bus.if_rsp_ready : io_bus.lsu_rsp_ready);

  // next-state and request-ready decode
  always_comb begin
    w_state_nxt = r_state;
    w_if_ready  = 1'b0;
    w_lsu_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // ready is masked during reset so every output reads 0 while it is held
        if (!i_reset) begin
          w_if_ready  = w_grant[0];
          w_lsu_ready = w_grant[1];
        end else begin
          w_if_ready  = 1'b0;
          w_lsu_ready = 1'b0;
        end
        if (|w_grant) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // request latches, latency counter and response register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner      <= OWN_IF;
      r_last_grant <= OWN_IF;
      r_we         <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= {DATA_W{1'b0}};
      r_wmask      <= {MASK_W{1'b0}};
      r_lat_cnt    <= {LAT_CNT_W{1'b0}};
      r_rdata      <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner      <= w_grant[1] ? OWN_LSU : OWN_IF;
            r_last_grant <= w_grant[1] ? OWN_LSU : OWN_IF;
            r_we         <= w_grant[1] & io_bus.lsu_req_we;
            r_addr       <= w_grant[1] ? io_bus.lsu_req_addr  : io_bus.if_req_addr;
            r_wdata      <= w_grant[1] ? io_bus.lsu_req_wdata : {DATA_W{1'b0}};
            r_wmask      <= w_grant[1] ? io_bus.lsu_req_wmask : {MASK_W{1'b0}};
            r_lat_cnt    <= {LAT_CNT_W{1'b0}};
          end
        end
        ST_ACCESS: begin
          r_lat_cnt <= r_lat_cnt + {{(LAT_CNT_W-1){1'b0}}, 1'b1};
          if (r_lat_cnt == LAT_LAST) begin
            r_rdata <= r_we ? {DATA_W{1'b0}} : io_bus.mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.if_req_ready  = w_if_ready;
  assign io_bus.lsu_req_ready = w_lsu_ready;

  assign io_bus.if_rsp_valid  = w_resp & (r_owner == OWN_IF);
  assign io_bus.if_rsp_rdata  = (w_resp & (r_owner == OWN_IF))  ? r_rdata : {DATA_W{1'b0}};
  assign io_bus.lsu_rsp_valid = w_resp & (r_owner == OWN_LSU);
  assign io_bus.lsu_rsp_rdata = (w_resp & (r_owner == OWN_LSU)) ? r_rdata : {DATA_W{1'b0}};

  assign io_bus.mem_ce    = w_access;
  assign io_bus.mem_we    = w_access & r_we;
  assign io_bus.mem_addr  = w_access ? r_addr  : {ADDR_W{1'b0}};
  assign io_bus.mem_wdata = w_access ? r_wdata : {DATA_W{1'b0}};
  assign io_bus.mem_wmask = w_access ? r_wmask : {MASK_W{1'b0}};

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single DPI-backed data memory port. It shares that port between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- At most one transaction is outstanding.
- The memory port is driven only from registered state, for one access window per transaction.

Parameters:
ADDR_W, 64, address width of requests and memory port
DATA_W, 64, data width; wmask width is DATA_W/8
MEM_LAT, 1, cycles mem_ce is held in ACCESS before mem_rdata is captured (legal values 1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
if_req_valid  input  1  IF read request
if_req_ready  output  1  IF request accepted this cycle
if_req_addr  input  ADDR_W  IF read address
if_rsp_valid  output  1  IF read data valid
if_rsp_ready  input  1  IF consumes response
if_rsp_rdata  output  DATA_W  IF read data
lsu_req_valid  input  1  LSU request
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_req_we  input  1  1 = write, 0 = read
lsu_req_addr  input  ADDR_W  LSU address
lsu_req_wdata  input  DATA_W  LSU write data
lsu_req_wmask  input  DATA_W/8  LSU byte mask
lsu_rsp_valid  output  1  LSU response valid (reads and writes)
lsu_rsp_ready  input  1  LSU consumes response
lsu_rsp_rdata  output  DATA_W  LSU read data; 0 for writes
mem_ce  output  1  memory chip enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wmask  output  DATA_W/8  memory byte mask
mem_rdata  input  DATA_W  memory read data, combinational from mem_addr

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- On reset, all outputs are 0, state is IDLE, last_grant = IF, lat_cnt = 0 and the response data register is 0.
- Reset asserted in any state aborts the transaction in progress. No response is delivered, and mem_ce drops on the next edge.

IDLE:
- req_ready is combinational and asserted only toward the selected requester.
- Selection when exactly one valid: that requester.
- Selection when both valid: the one not in last_grant (round-robin). After reset, LSU wins the first tie.
- On handshake, latch owner, we (forced 0 for IF), addr, wdata, wmask (forced 0 for IF). Update last_grant, clear lat_cnt, go to ACCESS.
- No handshake means stay in IDLE.

ACCESS:
- mem_ce = 1. mem_we/addr/wdata/wmask come from the latches and are stable for the whole state.
- lat_cnt increments each cycle. When lat_cnt == MEM_LAT-1:
  - Read: capture mem_rdata into the response register.
  - Write: load 0 into the response register.
  - Go to RESP.
- Both req_ready outputs are 0.

RESP:
- mem_ce = 0; mem_we, mem_addr, mem_wdata and mem_wmask are all 0.
- Only the owner's rsp_valid = 1, with rsp_rdata = response register.
- rsp_valid and rsp_rdata hold stable until the owner's rsp_ready = 1. Then go to IDLE the next cycle.
- A new request cannot be accepted in the same cycle as the response handshake.

General rules:
- Total latency with MEM_LAT = 1 and rsp_ready held high: request handshake at cycle N, mem_ce in cycle N+1, rsp_valid in cycle N+2, IDLE in cycle N+3.
- The non-owner's rsp_valid and rsp_rdata are always 0.
- Requester inputs are don't-care except during an IDLE handshake. Changes after acceptance do not affect mem_* outputs.
- When an output is inactive it is 0, never X.

Decomposition:
- Shared package: state encoding (IDLE=0, ACCESS=1, RESP=2) and owner encoding (OWN_IF=0, OWN_LSU=1).
- One sub-module is natural: mem_arb_rr2. It is a 2-way round-robin picker with inputs valid[1:0] and last_grant, and outputs grant[1:0].
- The FSM, latches and latency counter live in the top module.
- mem_arbiter instantiates the existing memory module, or exports mem_* for the SoC top to connect.

Test Plan:
- IF alone reads addr 0x80000000, memory returns 0x0000_0013_0000_0297, MEM_LAT=1, if_rsp_ready=1 -> if_req_ready in cycle 0, mem_ce=1/mem_we=0 in cycle 1, if_rsp_valid with that data in cycle 2, idle in cycle 3.
- LSU write of addr 0x80001000, wdata 0xDEADBEEF_CAFEF00D, wmask 0x0F -> mem_we=1 with exact addr/wdata/wmask for one cycle, lsu_rsp_valid with rdata 0, if_rsp_valid stays 0.
- Both valid every cycle from reset -> grants alternate LSU, IF, LSU, IF over 4 transactions. Each response is routed only to its owner.
- lsu_rsp_ready held 0 for 5 cycles in RESP -> lsu_rsp_valid/rdata stable, mem_ce=0, if_req_ready=0 throughout. IF is accepted in the cycle after the ready handshake.
- MEM_LAT=3 read -> mem_ce high exactly 3 cycles with stable addr. Data is captured from the final cycle; a mem_rdata change in the first cycle has no effect.
- Reset asserted during ACCESS -> next cycle all outputs 0, state IDLE. A following LSU-vs-IF tie grants LSU.
